// File: rtl/avalon_mm_burst_reader_pkg.sv
// avalon_mm_burst_reader_pkg: FSM states and shared constants for the burst reader
package avalon_mm_burst_reader_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
    localparam int BYTES_PER_WORD = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W = 16;
endpackage

// File: rtl/avalon_mm_burst_reader_if.sv
// avalon_mm_burst_reader_if: command, Avalon-MM read master and Avalon-ST byte source signals
interface avalon_mm_burst_reader_if
    import avalon_mm_burst_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W = DEF_LEN_W
);
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;
    logic              cmd_busy;
    logic              cmd_done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [31:0]       avm_readdata;
    logic [7:0]        src_data;
    logic              src_valid;
    logic              src_ready;
    logic              src_eop;

    modport master (
        input  cmd_start, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, src_ready,
        output cmd_busy, cmd_done, avm_address, avm_read, avm_byteenable, src_data, src_valid, src_eop
    );
    modport slave (
        output cmd_start, cmd_addr, cmd_len, avm_waitrequest, avm_readdata, src_ready,
        input  cmd_busy, cmd_done, avm_address, avm_read, avm_byteenable, src_data, src_valid, src_eop
    );
endinterface

// File: rtl/avalon_mm_burst_reader_fifo.sv
// avalon_mm_burst_reader_fifo: show-ahead synchronous word FIFO with occupancy count
module avalon_mm_burst_reader_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    always_comb begin
        empty = count == '0;
        full = count == (AW+1)'(DEPTH);
        do_push = push && !full;
        do_pop = pop && !empty;
        dout = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/avalon_mm_burst_reader.sv
// avalon_mm_burst_reader: credit-limited Avalon-MM block reader feeding a little-endian byte stream
module avalon_mm_burst_reader
    import avalon_mm_burst_reader_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int READ_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset_n,
    avalon_mm_burst_reader_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);
    state_t state, state_n;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0] remaining, words_out;
    logic [CW-1:0] inflight, fifo_count, credit;
    logic [READ_LATENCY-1:0] lat_sr;
    logic [31:0] fifo_dout, word;
    logic [1:0] idx;
    logic have_word, last_word, busy, done;
    logic start, accept, push, pop, fire, complete, fifo_empty, fifo_full;

    avalon_mm_burst_reader_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .din(bus.avm_readdata),
        .dout(fifo_dout), .count(fifo_count), .empty(fifo_empty), .full(fifo_full)
    );

    always_comb begin
        start = state == IDLE && bus.cmd_start;
        credit = fifo_count + inflight;
        bus.avm_read = state == ISSUE && remaining != '0 && credit < CW'(FIFO_DEPTH);
        accept = bus.avm_read && !bus.avm_waitrequest;
        push = lat_sr[READ_LATENCY-1];
        fire = have_word && bus.src_ready;
        pop = !fifo_empty && (!have_word || (fire && idx == LAST_IDX));
        complete = state == DRAIN && inflight == '0 && fifo_empty && !have_word;
        state_n = state == IDLE  ? (start && bus.cmd_len != '0 ? ISSUE : IDLE)
                : state == ISSUE ? (accept && remaining == LEN_W'(1) ? DRAIN : ISSUE)
                : state == DRAIN ? (complete ? IDLE : DRAIN)
                : IDLE;
        bus.avm_address = addr;
        bus.avm_byteenable = 4'hF;
        bus.src_valid = have_word;
        bus.src_data = word[{idx, 3'b000} +: 8];
        bus.src_eop = have_word && last_word && idx == LAST_IDX;
        bus.cmd_busy = busy;
        bus.cmd_done = done;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            addr <= '0;
            remaining <= '0;
            words_out <= '0;
            inflight <= '0;
            lat_sr <= '0;
            word <= '0;
            idx <= '0;
            have_word <= 1'b0;
            last_word <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            lat_sr <= READ_LATENCY'({lat_sr, accept});
            inflight <= inflight + CW'(accept) - CW'(push);
            busy <= start ? bus.cmd_len != '0 : busy && !complete;
            done <= (start && bus.cmd_len == '0) || complete;
            if (start) begin
                addr <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end else if (accept) begin
                addr <= addr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            // words_out counts words not yet handed to the serializer, marking the final one for eop
            if (start) words_out <= bus.cmd_len;
            else if (pop) words_out <= words_out - LEN_W'(1);
            if (pop) begin
                word <= fifo_dout;
                idx <= '0;
                have_word <= 1'b1;
                last_word <= words_out == LEN_W'(1);
            end else if (fire) begin
                idx <= idx + 2'd1;
                have_word <= idx != LAST_IDX;
            end
        end
    end

    a_credit: assert property (@(posedge clk) disable iff (!reset_n) credit <= CW'(FIFO_DEPTH));
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n) !(push && fifo_full));
endmodule

// File: tb/tb_avalon_mm_burst_reader.sv
// tb_avalon_mm_burst_reader: scoreboard bench with a one-cycle-latency memory model
module tb_avalon_mm_burst_reader;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    avalon_mm_burst_reader_if bus();
    avalon_mm_burst_reader dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int errors = 0, checks = 0;
    logic [31:0] mem [0:65535];
    logic [8:0] exp_q [$];
    logic [15:0] addr_q [$];
    logic [8:0] exp_e;
    int done_cnt = 0, read_cycles = 0, accepts = 0, bytes_rx = 0, stall_seen = 0;
    int cyc = 0, start_cyc = 0, lat = -1;
    int stall_idx = -1, stall_left = 0;
    bit rand_ready = 1'b0;
    logic [15:0] hold_addr = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(posedge clk)
        if (bus.avm_read && !bus.avm_waitrequest) bus.avm_readdata <= mem[bus.avm_address];

    always @(negedge clk) begin
        cyc++;
        if (reset_n) begin
            if (bus.cmd_start && !bus.cmd_busy) begin
                start_cyc = cyc;
                lat = -1;
            end
            if (bus.src_valid && lat < 0) lat = cyc - start_cyc;
            if (bus.cmd_done) done_cnt++;
            if (bus.avm_read) read_cycles++;
            if (bus.avm_read && !bus.avm_waitrequest) begin
                accepts++;
                addr_q.push_back(bus.avm_address);
            end
            if (bus.avm_waitrequest) begin
                stall_seen++;
                chk("hold_read", 32'(bus.avm_read), 32'd1);
                chk("hold_addr", 32'(bus.avm_address), 32'(hold_addr));
            end
            if (bus.src_valid && bus.src_ready) begin
                bytes_rx++;
                if (exp_q.size() == 0) chk("extra_byte", 32'({bus.src_eop, bus.src_data}), 32'hDEAD0000);
                else begin
                    exp_e = exp_q.pop_front();
                    chk("byte", 32'({bus.src_eop, bus.src_data}), 32'(exp_e));
                end
            end
        end
    end

    // ready and waitrequest change just after the edge so both sides see them stable
    initial forever begin
        @(posedge clk);
        #1;
        bus.src_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
        if (stall_left > 0 && (stall_left < 3 || (bus.avm_read && accepts == stall_idx))) begin
            bus.avm_waitrequest = 1'b1;
            stall_left--;
        end else bus.avm_waitrequest = 1'b0;
    end

    task automatic start_cmd(input logic [15:0] a, input logic [15:0] n);
        logic [31:0] d;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b1;
        bus.cmd_addr = a;
        bus.cmd_len = n;
        for (int w = 0; w < int'(n); w++) begin
            d = mem[(int'(a) + w) & 16'hFFFF];
            for (int b = 0; b < 4; b++) exp_q.push_back({w == int'(n) - 1 && b == 3, d[8*b +: 8]});
        end
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < 2000), 32'd1);
        repeat (5) @(posedge clk);
        chk({tag, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0, r0;
        logic [15:0] exp_a [3];
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, r0;
        logic [15:0] exp_a [3];
        bus.cmd_start = 1'b0;
        bus.cmd_addr = '0;
        bus.cmd_len = '0;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = '0;
        bus.src_ready = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = {16'(i), ~16'(i)};
        mem[16'h0010] = 32'h44332211;
        mem[16'h0011] = 32'h88776655;
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = $urandom;
        mem[16'hFFFE] = 32'hA3A2A1A0;
        mem[16'hFFFF] = 32'hB3B2B1B0;
        mem[16'h0000] = 32'hC3C2C1C0;
        mem[16'h0020] = 32'hDDCCBBAA;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.cmd_busy), 32'd0);
        chk("rst_done", 32'(bus.cmd_done), 32'd0);
        chk("rst_read", 32'(bus.avm_read), 32'd0);
        chk("rst_addr", 32'(bus.avm_address), 32'd0);
        chk("rst_valid", 32'(bus.src_valid), 32'd0);
        chk("rst_eop", 32'(bus.src_eop), 32'd0);
        chk("rst_data", 32'(bus.src_data), 32'd0);
        chk("byteenable", 32'(bus.avm_byteenable), 32'hF);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // T1: two words, always ready, plus an ignored start while busy
        d0 = done_cnt;
        addr_q.delete();
        start_cmd(16'h0010, 16'd2);
        @(negedge clk);
        chk("t1_busy", 32'(bus.cmd_busy), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b1;
        bus.cmd_addr = 16'h0200;
        bus.cmd_len = 16'd5;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
        wait_done("t1", d0);
        chk("t1_latency_ok", 32'(lat >= 3), 32'd1);
        chk("t1_naddr", 32'(addr_q.size()), 32'd2);
        chk("t1_busy_end", 32'(bus.cmd_busy), 32'd0);

        // T2: zero length
        d0 = done_cnt;
        r0 = read_cycles;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b1;
        bus.cmd_addr = 16'h0005;
        bus.cmd_len = 16'd0;
        @(posedge clk);
        #1;
        bus.cmd_start = 1'b0;
        @(negedge clk);
        chk("t2_done", 32'(bus.cmd_done), 32'd1);
        chk("t2_busy", 32'(bus.cmd_busy), 32'd0);
        repeat (5) @(posedge clk);
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("t2_no_read", 32'(read_cycles - r0), 32'd0);

        // T3: eight words with a sink ready 30% of the time
        d0 = done_cnt;
        rand_ready = 1'b1;
        start_cmd(16'h0100, 16'd8);
        wait_done("t3", d0);
        rand_ready = 1'b0;

        // T4: address wrap
        d0 = done_cnt;
        addr_q.delete();
        start_cmd(16'hFFFE, 16'd3);
        wait_done("t4", d0);
        exp_a = '{16'hFFFE, 16'hFFFF, 16'h0000};
        chk("t4_naddr", 32'(addr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            if (i < addr_q.size()) chk("t4_addr", 32'(addr_q[i]), 32'(exp_a[i]));

        // T5: three-cycle waitrequest on the second read
        d0 = done_cnt;
        stall_seen = 0;
        stall_idx = accepts + 1;
        stall_left = 3;
        hold_addr = 16'h0041;
        start_cmd(16'h0040, 16'd4);
        wait_done("t5", d0);
        chk("t5_stalls", 32'(stall_seen), 32'd3);

        // T6: reset mid-transfer, then a fresh one-word read
        start_cmd(16'h0030, 16'd6);
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t6_rst_valid", 32'(bus.src_valid), 32'd0);
        chk("t6_rst_busy", 32'(bus.cmd_busy), 32'd0);
        d0 = done_cnt;
        bytes_rx = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        start_cmd(16'h0020, 16'd1);
        wait_done("t6", d0);
        chk("t6_bytes", 32'(bytes_rx), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
